// File: rtl/memory_writeback_cycle_if.sv
// Data-memory request/acknowledge bus between the memory stage and the
// data memory (or its arbiter).
//   dmem_req    request, held high until dmem_ack
//   dmem_we     1 = store, 0 = load
//   dmem_addr   word-aligned byte address
//   dmem_be     byte enables
//   dmem_wdata  lane-replicated store data
//   dmem_ack    request completes this cycle
//   dmem_rdata  load word, valid with dmem_ack
interface memory_writeback_cycle_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/memory_writeback_cycle.sv
// Memory and writeback stages of the RV32I pipeline.
// Takes the M-stage bundle, issues data-memory accesses over the dmem bus,
// formats store lanes and load data, and produces the registered write-back
// triple (RegWriteW, RDW, ResultW) plus a one-cycle FaultW pulse.
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   ValidM .. PCPlus4M    M-stage bundle from the execute pipeline register
//   StallM                freezes the M bundle and earlier stages
//   dmem                  data-memory bus (master side)
//   RegWriteW, RDW,       registered write-back triple for the register file
//   ResultW                 and the decode-stage forwarding muxes
//   FaultW                misaligned access or illegal width, one-cycle pulse
module memory_writeback_cycle (
  input  logic        clock,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  memory_writeback_cycle_if.master dmem,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        FaultW
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        regwrite_q, regwrite_d;
  logic [1:0]  off_q, off_d;
  logic        regwrite_w_q, regwrite_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] result_w_q, result_w_d;
  logic        fault_w_q, fault_w_d;

  logic        mem_op;
  logic        width_ok;
  logic        align_ok;
  logic        mem_fault;
  logic        mem_start;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] lane;
  logic [31:0] load_fmt;
  logic [31:0] alu_sel;

  // A load encoding with MemWriteM set is a store.
  assign mem_op = ValidM & ((ResultSrcM == 2'b01) | MemWriteM);

  // Width legality depends on direction: unsigned codes exist only for loads.
  always_comb begin
    width_ok = 1'b0;
    align_ok = 1'b0;
    case (funct3M)
      3'b000: begin width_ok = 1'b1;        align_ok = 1'b1;                     end
      3'b001: begin width_ok = 1'b1;        align_ok = ~ALUResultM[0];           end
      3'b010: begin width_ok = 1'b1;        align_ok = (ALUResultM[1:0] == 2'b00); end
      3'b100: begin width_ok = ~MemWriteM;  align_ok = 1'b1;                     end
      3'b101: begin width_ok = ~MemWriteM;  align_ok = ~ALUResultM[0];           end
      default: begin width_ok = 1'b0;       align_ok = 1'b0;                     end
    endcase
  end

  assign mem_fault = mem_op & ~(width_ok & align_ok);
  assign mem_start = mem_op & width_ok & align_ok;

  // Store lane formatting (loads reuse the enables to mark the lanes read).
  always_comb begin
    case (funct3M[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << ALUResultM[1:0];
        wdata_fmt = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata_fmt = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = WriteDataM;
      end
    endcase
  end

  // Load formatting uses the captured offset and width, not the live bundle.
  assign lane = dmem.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_fmt = {24'd0, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  always_comb begin
    case (ResultSrcM)
      2'b00:   alu_sel = ALUResultM;
      2'b10:   alu_sel = PCPlus4M;
      default: alu_sel = 32'd0;
    endcase
  end

  // The ack cycle releases the stall so the M bundle retires on that edge.
  assign StallM = (state_q == IDLE) ? mem_start : ~dmem.dmem_ack;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    regwrite_d   = regwrite_q;
    off_d        = off_q;
    // Default is a bubble: no write, no fault, RDW/ResultW hold.
    regwrite_w_d = 1'b0;
    rd_w_d       = rd_w_q;
    result_w_d   = result_w_q;
    fault_w_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_start) begin
          state_d    = ACCESS;
          req_d      = 1'b1;
          we_d       = MemWriteM;
          addr_d     = {ALUResultM[31:2], 2'b00};
          be_d       = be_fmt;
          wdata_d    = wdata_fmt;
          rd_d       = RD_M;
          funct3_d   = funct3M;
          regwrite_d = RegWriteM;
          off_d      = ALUResultM[1:0];
        end else if (mem_fault) begin
          fault_w_d = 1'b1;
        end else if (ValidM) begin
          regwrite_w_d = RegWriteM & (|RD_M);
          rd_w_d       = RD_M;
          result_w_d   = alu_sel;
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            regwrite_w_d = regwrite_q & (|rd_q);
            rd_w_d       = rd_q;
            result_w_d   = load_fmt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      rd_q         <= 5'd0;
      funct3_q     <= 3'd0;
      regwrite_q   <= 1'b0;
      off_q        <= 2'd0;
      regwrite_w_q <= 1'b0;
      rd_w_q       <= 5'd0;
      result_w_q   <= 32'd0;
      fault_w_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      regwrite_q   <= regwrite_d;
      off_q        <= off_d;
      regwrite_w_q <= regwrite_w_d;
      rd_w_q       <= rd_w_d;
      result_w_q   <= result_w_d;
      fault_w_q    <= fault_w_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign RegWriteW       = regwrite_w_q;
  assign RDW             = rd_w_q;
  assign ResultW         = result_w_q;
  assign FaultW          = fault_w_q;

endmodule

// File: tb/tb_memory_writeback_cycle.sv
// Scoreboard bench for memory_writeback_cycle: the issuing process pushes
// expected memory requests and write-back events; a memory responder and a
// write-back monitor pop and compare as the DUT presents them.
module tb_memory_writeback_cycle;

  logic        clock = 1'b0;
  logic        reset;
  logic        ValidM, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        StallM;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        FaultW;

  always #5 clock = ~clock;

  memory_writeback_cycle_if dmem_bus();

  memory_writeback_cycle dut (
    .clock(clock), .reset(reset),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RD_M(RD_M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .StallM(StallM), .dmem(dmem_bus),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FaultW(FaultW)
  );

  typedef struct { int cyc; logic rw; logic fault; logic [4:0] rd; logic [31:0] val; } wb_t;
  typedef struct { int cyc; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } req_t;
  typedef struct { int lat; logic [31:0] rdata; } rsp_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit resp_en = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit legal(input logic [2:0] f3, input bit store);
    if (store) return (f3 <= 3'd2);
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wd, input int sz);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] rdata, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] word;
    longint v;
    word = rdata >> (8 * off);
    case (f3)
      3'd0: begin v = word & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd4: v = word & 32'hFF;
      3'd1: begin v = word & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd5: v = word & 32'hFFFF;
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  // ---------------- issue one M-stage bundle ----------------
  // Called #1 after a rising edge; returns #1 after the edge that retires it.
  task automatic issue(input bit valid, input bit rw, input bit mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4, input int lat,
                       input logic [31:0] rdata);
    int c, exp_stall, n, sz;
    bit store, is_mem, flt;
    logic [31:0] val;
    wb_t w;
    req_t r;
    rsp_t p;
    c = cyc;
    exp_stall = 0;
    store = mw;
    is_mem = valid && (rs == 2'b01 || mw);
    if (valid && !is_mem) begin
      case (rs)
        2'b00:   val = alu;
        2'b10:   val = pc4;
        default: val = 32'd0;
      endcase
      if (rw && rd != 5'd0) begin
        w = '{c + 1, 1'b1, 1'b0, rd, val};
        wb_q.push_back(w);
      end
    end else if (is_mem) begin
      sz = size_of(f3);
      flt = !legal(f3, store) || ((int'(alu[1:0]) % sz) != 0);
      if (flt) begin
        w = '{c + 1, 1'b0, 1'b1, 5'd0, 32'd0};
        wb_q.push_back(w);
      end else begin
        r.cyc   = c + 1;
        r.addr  = alu & 32'hFFFF_FFFC;
        r.be    = 4'(((1 << sz) - 1) << alu[1:0]);
        r.wdata = store ? store_data(wd, sz) : 32'd0;
        r.we    = store;
        req_q.push_back(r);
        p = '{lat, rdata};
        rsp_q.push_back(p);
        exp_stall = lat + 1;
        if (!store && rw && rd != 5'd0) begin
          w = '{c + 2 + lat, 1'b1, 1'b0, rd, load_value(rdata, alu[1:0], f3)};
          wb_q.push_back(w);
        end
      end
    end
    ValidM = valid; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
    RD_M = rd; ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
    $display("tx cyc=%0d v=%0b rw=%0b mw=%0b src=%0d f3=%0d rd=%0d addr=%h wd=%h lat=%0d",
             c, valid, rw, mw, rs, f3, rd, alu, wd, lat);
    n = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!StallM) break;
      n++;
      if (n > 50) break;
    end
    checks++;
    if (n != exp_stall) begin
      errors++;
      $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", c, n, exp_stall);
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- memory responder / request checker ----------------
  bit   active = 1'b0;
  int   wait_left = 0;
  req_t cur;
  rsp_t cur_rsp;

  initial begin
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (resp_en && reset) begin
        if (dmem_bus.dmem_ack) begin
          dmem_bus.dmem_ack   = 1'b0;
          dmem_bus.dmem_rdata = $urandom;
          active = 1'b0;
          checks++;
          if (dmem_bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_after_ack cyc=%0d got=%0b exp=0", cyc, dmem_bus.dmem_req);
          end
        end else if (dmem_bus.dmem_req) begin
          if (!active) begin
            checks++;
            if (req_q.size() == 0 || rsp_q.size() == 0) begin
              errors++;
              $display("FAIL req_unexpected cyc=%0d addr=%h", cyc, dmem_bus.dmem_addr);
              cur_rsp = '{0, 32'd0};
            end else begin
              cur = req_q.pop_front();
              cur_rsp = rsp_q.pop_front();
              if (cyc != cur.cyc || dmem_bus.dmem_addr !== cur.addr || dmem_bus.dmem_we !== cur.we ||
                  (cur.we && (dmem_bus.dmem_be !== cur.be || dmem_bus.dmem_wdata !== cur.wdata))) begin
                errors++;
                $display("FAIL req_fields got cyc=%0d addr=%h we=%0b be=%b wd=%h exp cyc=%0d addr=%h we=%0b be=%b wd=%h",
                         cyc, dmem_bus.dmem_addr, dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_wdata,
                         cur.cyc, cur.addr, cur.we, cur.be, cur.wdata);
              end
              cur.addr  = dmem_bus.dmem_addr;
              cur.we    = dmem_bus.dmem_we;
              cur.be    = dmem_bus.dmem_be;
              cur.wdata = dmem_bus.dmem_wdata;
            end
            active = 1'b1;
            wait_left = cur_rsp.lat;
          end else begin
            checks++;
            if (dmem_bus.dmem_addr !== cur.addr || dmem_bus.dmem_we !== cur.we ||
                dmem_bus.dmem_be !== cur.be || dmem_bus.dmem_wdata !== cur.wdata) begin
              errors++;
              $display("FAIL req_stable cyc=%0d got addr=%h be=%b wd=%h exp addr=%h be=%b wd=%h",
                       cyc, dmem_bus.dmem_addr, dmem_bus.dmem_be, dmem_bus.dmem_wdata,
                       cur.addr, cur.be, cur.wdata);
            end
          end
          if (wait_left == 0) begin
            dmem_bus.dmem_ack   = 1'b1;
            dmem_bus.dmem_rdata = cur_rsp.rdata;
          end else begin
            wait_left--;
            dmem_bus.dmem_rdata = $urandom;
          end
        end
      end
    end
  end

  // ---------------- write-back monitor ----------------
  initial begin
    wb_t e;
    forever begin
      @(negedge clock);
      if (reset && (RegWriteW || FaultW)) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected cyc=%0d rw=%0b rd=%0d res=%h fault=%0b exp none",
                   cyc, RegWriteW, RDW, ResultW, FaultW);
        end else begin
          e = wb_q.pop_front();
          if (cyc != e.cyc || RegWriteW !== e.rw || FaultW !== e.fault ||
              (e.rw && (RDW !== e.rd || ResultW !== e.val))) begin
            errors++;
            $display("FAIL wb_event got cyc=%0d rw=%0b rd=%0d res=%h fault=%0b exp cyc=%0d rw=%0b rd=%0d res=%h fault=%0b",
                     cyc, RegWriteW, RDW, ResultW, FaultW, e.cyc, e.rw, e.rd, e.val, e.fault);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic check_all_zero(input string name);
    checks++;
    if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be,
         dmem_bus.dmem_wdata, RegWriteW, RDW, ResultW, FaultW, StallM} !== '0) begin
      errors++;
      $display("FAIL %s req=%0b we=%0b addr=%h be=%b wd=%h rw=%0b rd=%0d res=%h fault=%0b stall=%0b exp all 0",
               name, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_be,
               dmem_bus.dmem_wdata, RegWriteW, RDW, ResultW, FaultW, StallM);
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0] r1, r2, r3, r4;
    int kind;
    logic [1:0] rs;
    logic [2:0] f3;
    bit mw, rw;

    reset = 1'b0;
    ValidM = 0; RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; funct3M = 0;
    RD_M = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset_state");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Directed cases
    issue(1, 1, 0, 2'b00, 3'd0, 5'd5,  32'h0000_1234, 32'h0, 32'h0, 0, 32'h0);
    issue(1, 1, 0, 2'b01, 3'd0, 5'd6,  32'h0000_0103, 32'h0, 32'h0, 0, 32'h80FF_0000);
    issue(1, 1, 0, 2'b01, 3'd5, 5'd7,  32'h0000_0102, 32'h0, 32'h0, 0, 32'hBEEF_0000);
    issue(1, 1, 1, 2'b00, 3'd0, 5'd8,  32'h0000_0201, 32'h0000_00AB, 32'h0, 0, 32'h0);
    issue(1, 1, 0, 2'b01, 3'd2, 5'd9,  32'h0000_0206, 32'h0, 32'h0, 0, 32'h0);
    issue(1, 1, 0, 2'b01, 3'd2, 5'd10, 32'h0000_0400, 32'h0, 32'h0, 3, 32'hCAFE_F00D);
    issue(1, 1, 0, 2'b01, 3'd2, 5'd0,  32'h0000_0404, 32'h0, 32'h0, 1, 32'h1234_5678);
    issue(1, 1, 0, 2'b10, 3'd0, 5'd11, 32'h0000_0999, 32'h0, 32'h8000_0004, 0, 32'h0);
    issue(1, 1, 0, 2'b11, 3'd0, 5'd12, 32'h0000_0999, 32'h0, 32'h8000_0004, 0, 32'h0);
    issue(1, 1, 1, 2'b01, 3'd2, 5'd13, 32'h0000_0500, 32'hDEAD_BEEF, 32'h0, 2, 32'h0);
    issue(1, 0, 1, 2'b00, 3'd1, 5'd14, 32'h0000_0602, 32'h1234_5678, 32'h0, 1, 32'h0);
    issue(1, 0, 1, 2'b00, 3'd4, 5'd15, 32'h0000_0700, 32'h1234_5678, 32'h0, 0, 32'h0);
    issue(1, 1, 0, 2'b01, 3'd1, 5'd16, 32'h0000_0801, 32'h0, 32'h0, 0, 32'h0);
    issue(0, 1, 1, 2'b01, 3'd2, 5'd17, 32'h0000_0900, 32'h0, 32'h0, 0, 32'h0);

    // Randomized bundles
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
      rw = ($urandom_range(0, 3) != 0);
      mw = 1'b0;
      rs = 2'b00;
      f3 = 3'(r3[2:0]);
      if (kind <= 3) begin
        rs = (r3[4:3] == 2'b01) ? 2'b00 : 2'(r3[4:3]);
      end else if (kind <= 6) begin
        rs = 2'b01;
        if (r3[7:5] != 3'd0) f3 = (r3[2:0] == 3'd3) ? 3'd4 : (r3[2:0] >= 3'd6 ? 3'd5 : 3'(r3[2:0]));
      end else begin
        mw = 1'b1;
        rs = 2'(r3[4:3]);
        if (r3[7:5] != 3'd0) f3 = 3'(r3[1:0] == 2'b11 ? 2'b10 : r3[1:0]);
      end
      if (kind == 0) begin
        mw = r3[8];
        rs = 2'(r3[10:9]);
      end
      issue(kind != 0, rw, mw, rs, f3, 5'(r4[4:0]), r1, r2, r4,
            int'(r3[12:11]), $urandom);
    end

    // Drain: let the responder release ack and the monitor catch up.
    repeat (4) issue(0, 0, 0, 2'b00, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);

    // Reset in the middle of an access
    resp_en = 1'b0;
    ValidM = 1; RegWriteM = 1; MemWriteM = 0; ResultSrcM = 2'b01; funct3M = 3'd2;
    RD_M = 5'd9; ALUResultM = 32'h0000_0300;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    checks++;
    if (dmem_bus.dmem_req !== 1'b1 || StallM !== 1'b1) begin
      errors++;
      $display("FAIL access_before_reset req=%0b stall=%0b exp 1 1", dmem_bus.dmem_req, StallM);
    end
    ValidM = 0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_access");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h5555_AAAA;
    @(posedge clock);
    #1;
    dmem_bus.dmem_ack = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (RegWriteW !== 1'b0 || dmem_bus.dmem_req !== 1'b0 || StallM !== 1'b0) begin
        errors++;
        $display("FAIL late_ack rw=%0b req=%0b stall=%0b exp 0 0 0", RegWriteW, dmem_bus.dmem_req, StallM);
      end
    end

    checks++;
    if (wb_q.size() != 0 || req_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_left wb=%0d req=%0d rsp=%0d exp 0 0 0", wb_q.size(), req_q.size(), rsp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
